banked_sdp_sram_buffer: RTL

// - Parametrised simple dual-port buffer. Write port is narrow; read port is wide (RATIO lanes).
// - Storage is built from RATIO lane banks. Reads have a configurable pipeline latency and a regceb-gated output register.
// - Read-during-write collision handling is selectable. A read-valid strobe is provided.
// - Successor to the fixed-width SDP wrapper; sits between the DMA write side and PE-array read side of the on-chip buffers.

---
 rtl/genesys_buf_pkg.sv | 36 +++
 rtl/banked_sdp_sram_buffer_chk.sv | 22 ++
 rtl/sdp_sram_bank.sv | 41 ++++
 rtl/banked_sdp_sram_buffer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/genesys_buf_pkg.sv
// Shared constants and width helpers for the on-chip buffer family.
package genesys_buf_pkg;

  // Read-during-write collision modes.
  localparam bit WR_FIRST = 1'b1;
  localparam bit RD_FIRST = 1'b0;

  // Address width for a given number of entries, never narrower than one bit.
  function automatic int unsigned read_addr_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

  // Number of address bits that select a lane inside a read row.
  function automatic int unsigned lane_bits(input int unsigned ratio);
    return (ratio > 32'd1) ? $clog2(ratio) : 32'd0;
  endfunction

  // Write-side address is {row, lane}.
  function automatic int unsigned write_addr_width(input int unsigned depth,
                                                   input int unsigned ratio);
    return read_addr_width(depth) + lane_bits(ratio);
  endfunction

  // Wide read word is RATIO narrow lanes side by side.
  function automatic int unsigned read_width(input int unsigned ww,
                                             input int unsigned ratio);
    return ww * ratio;
  endfunction

  // True when a row index addresses real storage.
  function automatic logic in_range(input int unsigned idx,
                                    input int unsigned depth);
    return (idx < depth);
  endfunction

endpackage

// File: rtl/banked_sdp_sram_buffer_chk.sv
// Simulation checks on the address ranges presented to the buffer.
module banked_sdp_sram_buffer_chk
  import genesys_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input logic          clk,
  input logic          rst_n,
  input logic          wr,
  input logic [AW-1:0] wrow,
  input logic          rd,
  input logic [AW-1:0] rrow
);

  a_wr_row_range: assert property (@(posedge clk) disable iff (!rst_n)
                                   wr |-> in_range(32'(wrow), DEPTH));

  a_rd_row_range: assert property (@(posedge clk) disable iff (!rst_n)
                                   rd |-> in_range(32'(rrow), DEPTH));

endmodule

// File: rtl/sdp_sram_bank.sv
// One lane of the buffer: WIDTH x DEPTH, one write port, one registered
// read port. Same-row read and write in one cycle returns the old contents.
module sdp_sram_bank
  import genesys_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Write port; rows beyond the array are dropped.
  always_ff @(posedge clk) begin
    if (we && in_range(32'(waddr), DEPTH)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its last value when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/banked_sdp_sram_buffer.sv
// Narrow-write / wide-read buffer built from RATIO lane banks, with a
// configurable read pipeline, a regceb-gated output register and selectable
// read-during-write behaviour. Sits between the DMA writer and the PE reader.
module banked_sdp_sram_buffer
  import genesys_buf_pkg::*;
#(
  parameter int unsigned WRITE_WIDTH      = 8,
  parameter int unsigned RATIO            = 4,
  parameter int unsigned BUFFER_DEPTH     = 128,
  parameter int unsigned READ_LATENCY_B   = 2,
  parameter bit          WRITE_FIRST      = WR_FIRST,
  parameter int unsigned READ_ADDR_WIDTH  = read_addr_width(BUFFER_DEPTH),
  parameter int unsigned WRITE_ADDR_WIDTH = write_addr_width(BUFFER_DEPTH, RATIO)
) (
  input  logic                           clka,
  input  logic                           rstb,
  input  logic                           ena,
  input  logic                           wea,
  input  logic [WRITE_ADDR_WIDTH-1:0]    addra,
  input  logic [WRITE_WIDTH-1:0]         dina,
  input  logic                           enb,
  input  logic                           regceb,
  input  logic [READ_ADDR_WIDTH-1:0]     addrb,
  output logic [WRITE_WIDTH*RATIO-1:0]   doutb,
  output logic                           rvalidb,
  output logic                           sbiterrb,
  output logic                           dbiterrb
);

  localparam int unsigned RW = read_width(WRITE_WIDTH, RATIO);
  localparam int unsigned LB = lane_bits(RATIO);
  localparam int unsigned LW = (LB > 32'd0) ? LB : 32'd1;

  logic [LW-1:0]              lane_s;
  logic [READ_ADDR_WIDTH-1:0] row_s;
  logic                       wr_s;
  logic                       coll_s;
  logic [RATIO-1:0]           bank_we_s;
  logic [RW-1:0]              bank_rd_s;
  logic [RW-1:0]              s1_data_s;
  logic                       s1_valid_r;
  logic                       fwd_en_r;
  logic [LW-1:0]              fwd_lane_r;
  logic [WRITE_WIDTH-1:0]     fwd_data_r;

  // Lane and row are plain bit fields of the write address.
  if (LB > 32'd0) begin : g_lane
    assign lane_s = addra[LB-1:0];
    assign row_s  = addra[WRITE_ADDR_WIDTH-1:LB];
  end else begin : g_nolane
    assign lane_s = '0;
    assign row_s  = addra;
  end

  assign wr_s   = ena & wea;
  assign coll_s = wr_s & enb & (row_s == addrb);

  for (genvar k = 0; k < RATIO; k++) begin : g_bank
    assign bank_we_s[k] = wr_s & (lane_s == LW'(k));

    sdp_sram_bank #(
      .WIDTH (WRITE_WIDTH),
      .DEPTH (BUFFER_DEPTH),
      .AW    (READ_ADDR_WIDTH)
    ) u_bank (
      .clk   (clka),
      .rst_n (rstb),
      .we    (bank_we_s[k]),
      .waddr (row_s),
      .wdata (dina),
      .re    (enb),
      .raddr (addrb),
      .rdata (bank_rd_s[k*WRITE_WIDTH +: WRITE_WIDTH])
    );
  end

  // Stage-1 valid plus the same-cycle write captured for forwarding; the
  // forward info only changes with a new read so stage 1 holds between reads.
  always_ff @(posedge clka or negedge rstb) begin
    if (!rstb) begin
      s1_valid_r <= 1'b0;
      fwd_en_r   <= 1'b0;
      fwd_lane_r <= '0;
      fwd_data_r <= '0;
    end else begin
      s1_valid_r <= enb;
      if (enb) begin
        fwd_en_r   <= coll_s & WRITE_FIRST;
        fwd_lane_r <= lane_s;
        fwd_data_r <= dina;
      end
    end
  end

  // Stage-1 result: bank data with the colliding lane replaced when forwarding.
  always_comb begin
    s1_data_s = bank_rd_s;
    if (fwd_en_r) begin
      s1_data_s[32'(fwd_lane_r)*WRITE_WIDTH +: WRITE_WIDTH] = fwd_data_r;
    end else begin
      s1_data_s = bank_rd_s;
    end
  end

  if (READ_LATENCY_B == 32'd1) begin : g_lat1
    logic unused_regceb_s;
    assign unused_regceb_s = regceb;
    assign doutb           = s1_data_s;
    assign rvalidb         = s1_valid_r;
  end else begin : g_latn
    logic [RW-1:0] fin_d_s;
    logic          fin_v_s;
    logic [RW-1:0] dout_r;
    logic          rvalid_r;

    if (READ_LATENCY_B == 32'd2) begin : g_direct
      assign fin_d_s = s1_data_s;
      assign fin_v_s = s1_valid_r;
    end else begin : g_mid
      localparam int unsigned MID = READ_LATENCY_B - 32'd2;
      logic [RW-1:0] mid_d_r [MID];
      logic          mid_v_r [MID];

      // Free-running middle stages; the valid bit travels with its data.
      always_ff @(posedge clka or negedge rstb) begin
        if (!rstb) begin
          for (int i = 0; i < int'(MID); i++) begin
            mid_d_r[i] <= '0;
            mid_v_r[i] <= 1'b0;
          end
        end else begin
          mid_d_r[0] <= s1_data_s;
          mid_v_r[0] <= s1_valid_r;
          for (int i = 1; i < int'(MID); i++) begin
            mid_d_r[i] <= mid_d_r[i-1];
            mid_v_r[i] <= mid_v_r[i-1];
          end
        end
      end

      assign fin_d_s = mid_d_r[MID-1];
      assign fin_v_s = mid_v_r[MID-1];
    end

    // Output register: frozen while regceb=0; data only reloads on a completed read.
    always_ff @(posedge clka or negedge rstb) begin
      if (!rstb) begin
        dout_r   <= '0;
        rvalid_r <= 1'b0;
      end else if (regceb) begin
        rvalid_r <= fin_v_s;
        if (fin_v_s) begin
          dout_r <= fin_d_s;
        end
      end
    end

    assign doutb   = dout_r;
    assign rvalidb = rvalid_r;
  end

  assign sbiterrb = 1'b0;
  assign dbiterrb = 1'b0;

  banked_sdp_sram_buffer_chk #(
    .DEPTH (BUFFER_DEPTH),
    .AW    (READ_ADDR_WIDTH)
  ) u_chk (
    .clk   (clka),
    .rst_n (rstb),
    .wr    (wr_s),
    .wrow  (row_s),
    .rd    (enb),
    .rrow  (addrb)
  );

endmodule
